pr_axi_rd_arb: RTL
==================

# pr_axi_rd_arb

Read-channel arbiter that shares the single AXI4 read port of the PageRank accelerator between `NREQ` internal readers (vertex fetch, in-edge fetch, rank-array fetch, ...). It grants the AR channel round-robin, tags each burst's `arid_m` with the requester index, and steers returning R beats back to the owning requester by `rid_m`. It sits between the PageRank datapath readers and the AXI memory interface (`axi_emu` in simulation, the shell DRAM port in hardware).

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `MAX_OUT`, 4: maximum outstanding bursts per requester, 1..15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Asynchronous assert, active-low; deassertion is synchronous to `clk`.
- `req_valid`  in  NREQ  per-requester burst request.
- `req_addr`  in  NREQ*64  byte address; requester i is at bits [64i+63:64i].
- `req_len`  in  NREQ*8  AXI burst length minus 1; requester i is at bits [8i+7:8i].
- `req_ready`  out  NREQ  request accepted; at most one bit set per cycle.
- `resp_valid`  out  NREQ  R beat valid for requester i.
- `resp_data`  out  512  shared beat data, equal to `rdata_m`.
- `resp_last`  out  1  shared last flag, equal to `rlast_m`.
- `resp_ready`  in  NREQ  per-requester beat accept.
- `arid_m`, `araddr_m`, `arlen_m`, `arsize_m`, `arvalid_m`  out  16, 64, 8, 3, 1  AXI AR channel.
- `arready_m`  in  1  AXI AR channel.
- `rid_m`, `rdata_m`, `rresp_m`, `rlast_m`, `rvalid_m`  in  16, 512, 2, 1, 1  AXI R channel.
- `rready_m`  out  1  AXI R channel.
- `err_bad_id`  out  1  sticky flag: a beat arrived with `rid_m` >= `NREQ`.
- `err_resp`  out  1  sticky flag: a beat arrived with `rresp_m` != 0.

## Operation
- FSM has two states.
  - IDLE: the eligible set is `req_valid[i]` AND `outstanding[i] < MAX_OUT`.
    - If the set is non-empty, the round-robin picker selects winner w, searching from `rr_ptr` upward with wrap. `req_ready[w]` is asserted combinationally in that same cycle.
    - On that cycle the block latches `araddr_m` = `req_addr[w]`, `arlen_m` = `req_len[w]`, and `arid_m` = w (zero-extended to 16 bits). It then sets `rr_ptr` = (w+1) mod NREQ and moves to ISSUE.
  - ISSUE: `arvalid_m` = 1, and all AR fields are held stable. On `arready_m` the FSM returns to IDLE and `arvalid_m` drops on the next edge.
- `arsize_m` is the constant `ARSIZE_64B` (3'd6) in every cycle.
- Outstanding counters, one per requester, each `$clog2(MAX_OUT+1)` bits wide:
  - +1 on AR handshake for that id.
  - -1 on an R handshake with `rlast_m` for that id.
  - If both happen in the same cycle, the counter is unchanged.
  - Decrement saturates at 0.
- R routing is purely combinational. With r = `rid_m`:
  - r < NREQ: `resp_valid[r]` = `rvalid_m`, all other bits of `resp_valid` are 0, and `rready_m` = `resp_ready[r]`.
  - r >= NREQ: `resp_valid` = 0, `rready_m` = 1 (the beat is dropped), and `err_bad_id` is set.
- `err_resp` is set on any R handshake with a non-zero `rresp_m`. The beat is still delivered.
- Sticky error flags clear only on reset.

## Timing
- Reset values: `arvalid_m`, `arid_m`, `araddr_m`, `arlen_m` = 0; `arsize_m` = 6; `rr_ptr` = 0; all counters = 0; both error flags = 0; FSM = IDLE.
- `rready_m`, `resp_valid`, `resp_data`, and `resp_last` follow the inputs combinationally in every state, including reset.
- AR latency:
  - Request accepted at edge t → `arvalid_m` high from t+1.
  - With `arready_m` tied high, the sustained rate is one burst per 2 cycles.
- AR-to-AR ordering across requesters is grant order. Beats may return interleaved by id, and routing never depends on order.
- A requester at `MAX_OUT` is skipped without stalling the others. If every requester is blocked, the FSM stays in IDLE.
- Reset asserted mid-ISSUE: `arvalid_m` drops immediately and counters clear. Beats still in flight afterwards are routed by id, and their decrements saturate at 0.

## Structure
- Add to the shared `pr_constants` include: `ARSIZE_64B`, `AXI_ID_W` (16), `AXI_ADDR_W` (64), `AXI_DATA_W` (512).
- Sub-module `pr_rr_pick`: purely combinational, parameterized by `N`.
  - Inputs: eligible mask and `rr_ptr`.
  - Outputs: one-hot grant, index, and an any-valid flag.
- Top-level logic is the FSM, the AR registers, the counter array, and the R demux.

## Test plan
- Single request: `req_valid[1]`, addr 0x140, len 3 → `req_ready[1]` for 1 cycle, then `arvalid_m` with `arid_m`=1, `araddr_m`=0x140, `arlen_m`=3, `arsize_m`=6. Four beats reach `resp_valid[1]` only, and the counter returns to 0.
- Round-robin: all 4 requesters continuously valid with `arready_m`=1 → grant order 0,1,2,3,0 at a 2-cycle spacing.
- Backpressure: `arready_m` held low for 5 cycles → AR fields stable throughout, no `req_ready`, exactly one handshake once released.
- Credit limit: `MAX_OUT`=2 and no R returned → requester 0 gets 2 grants and is then skipped while requester 2 is still granted. One rlast for id 0 re-enables it.
- Interleaved return: beats for ids 2,0,2,0 with `resp_ready[0]` low for 1 cycle → `rready_m` follows the owner, no beat lost, both counters reach 0.
- Errors and reset: `rid_m`=7 with `NREQ`=4 → beat dropped, `err_bad_id`=1. `rresp_m`=2 → `err_resp`=1. Asserting `rst` low during ISSUE → `arvalid_m`=0 and both flags clear.

Source files
------------

// File: rtl/pr_axi_rd_arb_pkg.sv
// pr_axi_rd_arb_pkg: shared AXI constants and types for the PageRank read arbiter.
//   ARSIZE_64B  : AR size code for full 512-bit beats
//   AXI_*_W     : AXI ID / address / data widths of the shell DRAM port
//   arb_state_e : AR issue FSM states
//   ar_req_t    : latched AR channel fields
package pr_axi_rd_arb_pkg;
  localparam logic [2:0] ARSIZE_64B = 3'd6;
  localparam int         AXI_ID_W   = 16;
  localparam int         AXI_ADDR_W = 64;
  localparam int         AXI_DATA_W = 512;

  typedef enum logic {ST_IDLE, ST_ISSUE} arb_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
  } ar_req_t;
endpackage

// File: rtl/pr_axi_rd_arb_rr_pick.sv
// pr_rr_pick: combinational round-robin picker.
//   elig : eligible mask
//   ptr  : highest-priority index this cycle
//   gnt  : one-hot grant
//   idx  : binary index of the grant
//   any  : at least one bit of elig is set
module pr_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk ptr, ptr+1, ... with wrap; first eligible candidate wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!any && elig[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt = N'(1) << idx;
  end
endmodule

// File: rtl/pr_axi_rd_arb.sv
// pr_axi_rd_arb: shares one AXI4 read port between NREQ readers.
//   req_*      : per-requester burst requests (req_ready is the accept pulse)
//   resp_*     : R beats steered back to the owner by rid_m
//   ar*_m      : AXI AR channel, arid_m carries the requester index
//   r*_m       : AXI R channel
//   err_bad_id : sticky, a beat arrived with an id outside 0..NREQ-1
//   err_resp   : sticky, a beat was accepted with a non-OKAY response
module pr_axi_rd_arb
  import pr_axi_rd_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ-1:0][AXI_ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][7:0]             req_len,
  output logic [NREQ-1:0]                  req_ready,
  output logic [NREQ-1:0]                  resp_valid,
  output logic [AXI_DATA_W-1:0]            resp_data,
  output logic                             resp_last,
  input  logic [NREQ-1:0]                  resp_ready,
  output logic [AXI_ID_W-1:0]              arid_m,
  output logic [AXI_ADDR_W-1:0]            araddr_m,
  output logic [7:0]                       arlen_m,
  output logic [2:0]                       arsize_m,
  output logic                             arvalid_m,
  input  logic                             arready_m,
  input  logic [AXI_ID_W-1:0]              rid_m,
  input  logic [AXI_DATA_W-1:0]            rdata_m,
  input  logic [1:0]                       rresp_m,
  input  logic                             rlast_m,
  input  logic                             rvalid_m,
  output logic                             rready_m,
  output logic                             err_bad_id,
  output logic                             err_resp
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  arb_state_e                state, state_nxt;
  ar_req_t                   ar_q;
  logic [IW-1:0]             rr_ptr;
  logic [NREQ-1:0][CW-1:0]   cnt;
  logic [NREQ-1:0]           elig, gnt, inc, dec;
  logic [IW-1:0]             win;
  logic                      any, ar_hs, r_hs, id_ok;
  logic [IW-1:0]             rid_lo;

  // Requesters at their credit limit drop out of the eligible set.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] && (cnt[i] < CW'(MAX_OUT));
  end

  pr_rr_pick #(.N(NREQ)) u_pick (
    .elig (elig),
    .ptr  (rr_ptr),
    .gnt  (gnt),
    .idx  (win),
    .any  (any)
  );

  // FSM
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE:  if (any) begin
                  req_ready = gnt;
                  state_nxt = ST_ISSUE;
                end
      ST_ISSUE: if (arready_m) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // AR fields latched at grant, held through ISSUE.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ar_q   <= '0;
      rr_ptr <= '0;
    end else if (state == ST_IDLE && any) begin
      ar_q.id   <= AXI_ID_W'(win);
      ar_q.addr <= req_addr[win];
      ar_q.len  <= req_len[win];
      rr_ptr    <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
    end

  assign arvalid_m = (state == ST_ISSUE);
  assign arid_m    = ar_q.id;
  assign araddr_m  = ar_q.addr;
  assign arlen_m   = ar_q.len;
  assign arsize_m  = ARSIZE_64B;
  assign ar_hs     = arvalid_m && arready_m;

  // R demux: ids outside the requester range are swallowed.
  assign id_ok     = rid_m < AXI_ID_W'(NREQ);
  assign rid_lo    = rid_m[IW-1:0];
  assign resp_data = rdata_m;
  assign resp_last = rlast_m;

  always_comb begin
    resp_valid = '0;
    rready_m   = 1'b1;
    if (id_ok) begin
      resp_valid[rid_lo] = rvalid_m;
      rready_m           = resp_ready[rid_lo];
    end
  end

  assign r_hs = rvalid_m && rready_m;

  // Outstanding-burst counters; simultaneous inc/dec cancel out.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREQ; i++) begin
      inc[i] = ar_hs && (arid_m == AXI_ID_W'(i));
      dec[i] = r_hs && rlast_m && (rid_m == AXI_ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else
      for (int i = 0; i < NREQ; i++) begin
        if (inc[i] && !dec[i])                     cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
      end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      err_bad_id <= 1'b0;
      err_resp   <= 1'b0;
    end else begin
      if (rvalid_m && !id_ok)        err_bad_id <= 1'b1;
      if (r_hs && rresp_m != 2'd0)   err_resp   <= 1'b1;
    end
endmodule
